// File: rtl/hd44780_pkg.sv
// hd44780_pkg
// Shared HD44780 definitions for the panel responder and the host-side driver:
// instruction opcode masks, DDRAM line start addresses, default line width,
// bus mode FSM encoding, RAM select, and the address-counter step helper.
package hd44780_pkg;

   localparam int unsigned LINE_WIDTH = 16;

   localparam logic [7:0] OP_CLEAR   = 8'h01;
   localparam logic [7:0] OP_HOME    = 8'h02;
   localparam logic [7:0] OP_ENTRY   = 8'h04;
   localparam logic [7:0] OP_DISPCTL = 8'h08;
   localparam logic [7:0] OP_SHIFT   = 8'h10;
   localparam logic [7:0] OP_FUNCSET = 8'h20;
   localparam logic [7:0] OP_CGRAM   = 8'h40;
   localparam logic [7:0] OP_DDRAM   = 8'h80;

   localparam logic [6:0] LINE0_ADDR = 7'h00;
   localparam logic [6:0] LINE1_ADDR = 7'h40;
   localparam logic [6:0] LINE2_ADDR = 7'h10;
   localparam logic [6:0] LINE3_ADDR = 7'h50;
   localparam logic [3:0][6:0] LINE_START = {LINE3_ADDR, LINE2_ADDR, LINE1_ADDR, LINE0_ADDR};

   typedef enum logic [1:0] {
      MODE_BYTE8,
      MODE_NIB_HI,
      MODE_NIB_LO
   } mode_t;

   typedef enum logic {
      RAM_DD,
      RAM_CG
   } ram_sel_t;

   // DDRAM address counter step with the controller's wrap points.
   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc,
                                          input logic two_line);
      logic [6:0] nxt;
      if (two_line) begin
         if (inc)
            nxt = (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
         else
            nxt = (ac == 7'h00) ? 7'h67 : (ac == 7'h40) ? 7'h27 : ac - 7'd1;
      end else begin
         if (inc)
            nxt = (ac == 7'h4F) ? 7'h00 : ac + 7'd1;
         else
            nxt = (ac == 7'h00) ? 7'h4F : ac - 7'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/hd44780_nibble_asm.sv
// hd44780_nibble_asm
// Synchronises the asynchronous E/RS/DB bus, detects E falling edges and
// assembles nibbles into bytes according to the current bus mode.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   lcd_e/rs/db     raw HD44780 bus inputs
//   strobe          1-cycle pulse on each synchronised E falling edge
//   byte_vld        1-cycle pulse, byte completed (1 cycle after strobe)
//   byte_rs         RS of the completed byte (high-nibble RS in 4-bit mode)
//   byte_data       completed byte
//   rs_mismatch     pulse with byte_vld when low-nibble RS differed
module hd44780_nibble_asm
   import hd44780_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic [3:0] lcd_db,
   output logic       strobe,
   output logic       byte_vld,
   output logic       byte_rs,
   output logic [7:0] byte_data,
   output logic       rs_mismatch
);

   logic       e_s1, e_s2, e_s3;
   logic       rs_s1, rs_s2;
   logic [3:0] db_s1, db_s2;
   logic [3:0] hi_nib;
   logic       hi_rs;
   mode_t      mode;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_s1  <= 1'b0;
         e_s2  <= 1'b0;
         e_s3  <= 1'b0;
         rs_s1 <= 1'b0;
         rs_s2 <= 1'b0;
         db_s1 <= '0;
         db_s2 <= '0;
      end else begin
         e_s1  <= lcd_e;
         e_s2  <= e_s1;
         e_s3  <= e_s2;
         rs_s1 <= lcd_rs;
         rs_s2 <= rs_s1;
         db_s1 <= lcd_db;
         db_s2 <= db_s1;
      end
   end

   assign strobe = e_s3 & ~e_s2;

   // Function set is 001x_xxxx with RS=0; DL is bit 4 (bit 0 of the high nibble).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode        <= MODE_BYTE8;
         hi_nib      <= '0;
         hi_rs       <= 1'b0;
         byte_vld    <= 1'b0;
         byte_rs     <= 1'b0;
         byte_data   <= '0;
         rs_mismatch <= 1'b0;
      end else begin
         byte_vld    <= 1'b0;
         rs_mismatch <= 1'b0;
         if (strobe) begin
            case (mode)
               MODE_BYTE8: begin
                  byte_data <= {db_s2, 4'b0000};
                  byte_rs   <= rs_s2;
                  byte_vld  <= 1'b1;
                  if (!rs_s2 && db_s2 == 4'b0010)
                     mode <= MODE_NIB_HI;
               end
               MODE_NIB_HI: begin
                  hi_nib <= db_s2;
                  hi_rs  <= rs_s2;
                  mode   <= MODE_NIB_LO;
               end
               MODE_NIB_LO: begin
                  byte_data   <= {hi_nib, db_s2};
                  byte_rs     <= hi_rs;
                  byte_vld    <= 1'b1;
                  rs_mismatch <= (rs_s2 != hi_rs);
                  if (!hi_rs && hi_nib == 4'b0011)
                     mode <= MODE_BYTE8;
                  else
                     mode <= MODE_NIB_HI;
               end
               default: mode <= MODE_BYTE8;
            endcase
         end
      end
   end

endmodule

// File: rtl/hd44780_panel_rx.sv
// hd44780_panel_rx
// LCD-side responder for the HD44780 parallel bus. Decodes instructions,
// tracks the DDRAM address counter and display configuration, and mirrors
// written characters into a 4-line shadow buffer with an independent read port.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   lcd_e/rs/db         HD44780 bus (E asynchronous to clk)
//   rd_addr / rd_data   shadow buffer read, 1-cycle latency
//   ac                  DDRAM address counter
//   four_bit, two_line, disp_on, cursor_on, blink_on, entry_inc  config bits
//   byte_vld/rs/data    completed byte report
//   busy                emulated busy flag
//   viol                1-cycle pulse on protocol/timing violation
module hd44780_panel_rx
   import hd44780_pkg::*;
#(
   parameter int unsigned LINE_WIDTH        = hd44780_pkg::LINE_WIDTH,
   parameter int unsigned CMD_BUSY_CYCLES   = 20,
   parameter int unsigned CLEAR_BUSY_CYCLES = 410
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic [3:0] lcd_db,
   input  logic [5:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [6:0] ac,
   output logic       four_bit,
   output logic       two_line,
   output logic       disp_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       entry_inc,
   output logic       byte_vld,
   output logic       byte_rs,
   output logic [7:0] byte_data,
   output logic       busy,
   output logic       viol
);

   localparam int unsigned DEPTH = 4 * LINE_WIDTH;
   localparam int unsigned TMR_W = $clog2(CLEAR_BUSY_CYCLES + 1);
   localparam logic [6:0]  LW7   = 7'(LINE_WIDTH);

   logic             strobe;
   logic             rs_mismatch;
   ram_sel_t         ram_sel;
   logic [TMR_W-1:0] tmr;
   logic             clr_active;
   logic [5:0]       clr_idx;
   logic             pend_vld;
   logic             pend_rs;
   logic [7:0]       pend_data;
   logic [7:0]       mem [DEPTH];

   logic             exec_vld;
   logic             exec_rs;
   logic [7:0]       exec_data;
   logic             is_slow;
   logic             map_ok;
   logic [5:0]       map_idx;
   logic [6:0]       off;
   logic             wr_en;
   logic [5:0]       wr_addr;
   logic [7:0]       wr_data;

   hd44780_nibble_asm u_asm (
      .clk         (clk),
      .rst         (rst),
      .lcd_e       (lcd_e),
      .lcd_rs      (lcd_rs),
      .lcd_db      (lcd_db),
      .strobe      (strobe),
      .byte_vld    (byte_vld),
      .byte_rs     (byte_rs),
      .byte_data   (byte_data),
      .rs_mismatch (rs_mismatch)
   );

   assign busy = (tmr != '0) || clr_active;

   // A pending byte always executes before a freshly completed one.
   always_comb begin
      exec_vld  = !clr_active && (pend_vld || byte_vld);
      exec_rs   = pend_vld ? pend_rs : byte_rs;
      exec_data = pend_vld ? pend_data : byte_data;
      is_slow   = !byte_rs && (byte_data[7:2] == 6'b0) && (byte_data[1:0] != 2'b0);
   end

   // Modular subtraction keeps the range test to a single compare per line.
   always_comb begin
      map_ok  = 1'b0;
      map_idx = '0;
      off     = '0;
      for (int unsigned l = 0; l < 4; l++) begin
         off = ac - LINE_START[l[1:0]];
         if (!map_ok && off < LW7) begin
            map_ok  = 1'b1;
            map_idx = 6'(l * LINE_WIDTH) + off[5:0];
         end
      end
   end

   always_comb begin
      wr_en   = clr_active || (exec_vld && exec_rs && ram_sel == RAM_DD && map_ok);
      wr_addr = clr_active ? clr_idx : map_idx;
      wr_data = clr_active ? 8'h20 : exec_data;
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rd_data <= '0;
      else
         rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ac         <= '0;
         four_bit   <= 1'b0;
         two_line   <= 1'b0;
         disp_on    <= 1'b0;
         cursor_on  <= 1'b0;
         blink_on   <= 1'b0;
         entry_inc  <= 1'b1;
         ram_sel    <= RAM_DD;
         tmr        <= '0;
         clr_active <= 1'b1;
         clr_idx    <= '0;
         pend_vld   <= 1'b0;
         pend_rs    <= 1'b0;
         pend_data  <= '0;
         viol       <= 1'b0;
      end else begin
         viol <= (strobe && busy) || rs_mismatch || (byte_vld && pend_vld && clr_active);

         if (byte_vld)
            tmr <= is_slow ? TMR_W'(CLEAR_BUSY_CYCLES) : TMR_W'(CMD_BUSY_CYCLES);
         else if (tmr != '0)
            tmr <= tmr - 1'b1;

         if (byte_vld && (clr_active || pend_vld)) begin
            pend_vld  <= 1'b1;
            pend_rs   <= byte_rs;
            pend_data <= byte_data;
         end else if (exec_vld && pend_vld) begin
            pend_vld <= 1'b0;
         end

         if (clr_active) begin
            clr_idx <= clr_idx + 6'd1;
            if (clr_idx == 6'(DEPTH - 1)) begin
               clr_active <= 1'b0;
               ac         <= '0;
               entry_inc  <= 1'b1;
               ram_sel    <= RAM_DD;
            end
         end else if (exec_vld) begin
            if (exec_rs) begin
               ac <= ac_step(ac, entry_inc, two_line);
            end else if (|(exec_data & OP_DDRAM)) begin
               ac      <= exec_data[6:0];
               ram_sel <= RAM_DD;
            end else if (|(exec_data & OP_CGRAM)) begin
               ram_sel <= RAM_CG;
            end else if (|(exec_data & OP_FUNCSET)) begin
               four_bit <= ~exec_data[4];
               two_line <= exec_data[3];
            end else if (|(exec_data & OP_SHIFT)) begin
               if (!exec_data[3])
                  ac <= ac_step(ac, exec_data[2], two_line);
            end else if (|(exec_data & OP_DISPCTL)) begin
               disp_on   <= exec_data[2];
               cursor_on <= exec_data[1];
               blink_on  <= exec_data[0];
            end else if (|(exec_data & OP_ENTRY)) begin
               entry_inc <= exec_data[1];
            end else if (|(exec_data & OP_HOME)) begin
               ac <= '0;
            end else if (|(exec_data & OP_CLEAR)) begin
               clr_active <= 1'b1;
               clr_idx    <= '0;
            end
         end
      end
   end

endmodule
